// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, saturation bounds and frame-length helper for the FIR output path
package fir_pkg;

  localparam int pDATA_WIDTH = 32;
  localparam int pOUT_WIDTH  = 16;
  localparam int pSHIFT_W    = 5;

  localparam logic [pOUT_WIDTH-1:0] SAT_MAX = {1'b0, {(pOUT_WIDTH-1){1'b1}}};
  localparam logic [pOUT_WIDTH-1:0] SAT_MIN = {1'b1, {(pOUT_WIDTH-1){1'b0}}};

  // A programmed length of zero behaves as a one-beat frame
  function automatic logic [31:0] len_norm(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/fir_requant_sat.sv
// rtl/fir_requant_sat.sv - combinational round-half-up shift and signed saturation
module fir_requant_sat #(
  parameter int pDATA_WIDTH = fir_pkg::pDATA_WIDTH,
  parameter int pOUT_WIDTH  = fir_pkg::pOUT_WIDTH,
  parameter int pSHIFT_W    = fir_pkg::pSHIFT_W
) (
  input  logic [pDATA_WIDTH-1:0] din,
  input  logic [pSHIFT_W-1:0]    shift,
  output logic [pDATA_WIDTH:0]   rs_y,
  input  logic [pDATA_WIDTH:0]   sat_in,
  output logic [pOUT_WIDTH-1:0]  sat_dout,
  output logic                   sat_flag
);

  // One extra bit so the rounding offset can never overflow
  localparam int YW = pDATA_WIDTH + 1;
  localparam logic signed [YW-1:0] Y_MAX = {{(YW-pOUT_WIDTH+1){1'b0}}, {(pOUT_WIDTH-1){1'b1}}};
  localparam logic signed [YW-1:0] Y_MIN = {{(YW-pOUT_WIDTH+1){1'b1}}, {(pOUT_WIDTH-1){1'b0}}};

  logic signed [YW-1:0] t;

  // Round half up by adding half an LSB of the result, then arithmetic shift
  always_comb begin
    t = {din[pDATA_WIDTH-1], din};
    if (shift != '0) begin
      t = t + (YW'(1) << (shift - pSHIFT_W'(1)));
    end
    rs_y = t >>> shift;
  end

  // Clamp the shifted value into the signed output range
  always_comb begin
    sat_dout = sat_in[pOUT_WIDTH-1:0];
    sat_flag = 1'b0;
    if ($signed(sat_in) > Y_MAX) begin
      sat_dout = Y_MAX[pOUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end else if ($signed(sat_in) < Y_MIN) begin
      sat_dout = Y_MIN[pOUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// rtl/fir_out_requant.sv - two-stage requantiser on the FIR output stream with frame/saturation status
module fir_out_requant #(
  parameter int pDATA_WIDTH = fir_pkg::pDATA_WIDTH,
  parameter int pOUT_WIDTH  = fir_pkg::pOUT_WIDTH,
  parameter int pSHIFT_W    = fir_pkg::pSHIFT_W
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pOUT_WIDTH-1:0]  m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  input  logic [pSHIFT_W-1:0]    cfg_shift,
  input  logic [31:0]            cfg_len,
  input  logic                   clr,
  output logic [15:0]            sat_cnt,
  output logic                   len_err,
  output logic                   done
);
  import fir_pkg::*;

  localparam int YW = pDATA_WIDTH + 1;

  logic                  v1, last1;
  logic [YW-1:0]         y1;
  logic                  v2, last2, sat2;
  logic [pOUT_WIDTH-1:0] d2;
  logic                  adv1, adv2, accept, first;
  logic [31:0]           cnt, cnt_inc, len_lat, len_eff;
  logic [pSHIFT_W-1:0]   sh_lat, sh_eff;
  logic [YW-1:0]         rs_y;
  logic [pOUT_WIDTH-1:0] sat_dout;
  logic                  sat_flag;

  // A stage may load when it is empty or its content moves on this cycle
  assign adv2     = !v2 || m_tready;
  assign adv1     = !v1 || adv2;
  assign s_tready = adv1 && !axis_rst;
  assign accept   = s_tvalid && s_tready;

  // The first beat of a frame uses the live config; later beats use the latched copy
  assign first    = (cnt == 32'd0);
  assign sh_eff   = first ? cfg_shift : sh_lat;
  assign len_eff  = first ? len_norm(cfg_len) : len_lat;
  assign cnt_inc  = cnt + 32'd1;

  assign m_tvalid = v2;
  assign m_tdata  = d2;
  assign m_tlast  = last2;

  fir_requant_sat #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pOUT_WIDTH  (pOUT_WIDTH),
    .pSHIFT_W    (pSHIFT_W)
  ) u_rq (
    .din      (s_tdata),
    .shift    (sh_eff),
    .rs_y     (rs_y),
    .sat_in   (y1),
    .sat_dout (sat_dout),
    .sat_flag (sat_flag)
  );

  // S1: capture the rounded and shifted sample
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      v1    <= 1'b0;
      y1    <= '0;
      last1 <= 1'b0;
    end else if (adv1) begin
      v1 <= accept;
      if (accept) begin
        y1    <= rs_y;
        last1 <= s_tlast;
      end
    end
  end

  // S2: saturate into the output register, held while the sink stalls
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      v2    <= 1'b0;
      d2    <= '0;
      last2 <= 1'b0;
      sat2  <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        d2    <= sat_dout;
        last2 <= last1;
        sat2  <= sat_flag;
      end
    end
  end

  // Frame tracking: beat counter, config latch and sticky length error
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      cnt     <= '0;
      len_lat <= 32'd1;
      sh_lat  <= '0;
      len_err <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      len_err <= 1'b0;
    end else if (accept) begin
      if (first) begin
        sh_lat  <= cfg_shift;
        len_lat <= len_eff;
      end
      if (s_tlast != (cnt_inc == len_eff)) begin
        len_err <= 1'b1;
      end
      cnt <= s_tlast ? 32'd0 : cnt_inc;
    end
  end

  // Saturation event counter, bumped as a clamped beat leaves S2, sticks at all-ones
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      sat_cnt <= '0;
    end else if (clr) begin
      sat_cnt <= '0;
    end else if (v2 && m_tready && sat2 && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  // End-of-frame pulse one cycle after the tlast beat handshakes
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      done <= 1'b0;
    end else begin
      done <= v2 && m_tready && last2;
    end
  end

endmodule
